// File: rtl/sram_port_arbiter_if.sv
// Client and SRAM-side signal bundle for sram_port_arbiter.
// slave is the arbiter's view; master is the stage/SRAM-model side.
interface sram_port_arbiter_if #(
  parameter int NUM_CLIENTS = 6,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 128
);
  logic [NUM_CLIENTS-1:0]        cli_req;
  logic [NUM_CLIENTS-1:0]        cli_lock;
  logic [NUM_CLIENTS-1:0]        cli_we;
  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr;
  logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata;
  logic [NUM_CLIENTS-1:0]        cli_gnt;
  logic [NUM_CLIENTS-1:0]        cli_rvalid;
  logic [DATA_W-1:0]             cli_rdata;
  logic                          sram_read;
  logic                          sram_write;
  logic [ADDR_W-1:0]             sram_addr;
  logic [DATA_W-1:0]             sram_wdata;
  logic [DATA_W-1:0]             sram_rdata;
  logic                          lock_timeout;

  modport slave (
    input  cli_req, cli_lock, cli_we, cli_addr, cli_wdata, sram_rdata,
    output cli_gnt, cli_rvalid, cli_rdata, sram_read, sram_write,
           sram_addr, sram_wdata, lock_timeout
  );

  modport master (
    output cli_req, cli_lock, cli_we, cli_addr, cli_wdata, sram_rdata,
    input  cli_gnt, cli_rvalid, cli_rdata, sram_read, sram_write,
           sram_addr, sram_wdata, lock_timeout
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with owner lock for the shared working SRAM; issues one
// registered command per grant and routes read data back with a tag pipeline.
module sram_port_arbiter #(
  parameter int NUM_CLIENTS = 6,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 128,
  parameter int RD_LAT      = 0,
  parameter int LOCK_MAX    = 16
) (
  input logic                clk,
  input logic                rst,
  sram_port_arbiter_if.slave bus
);
  localparam int         IDX_W    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  logic [IDX_W-1:0]       rrPtr;
  logic                   ownerValid;
  logic [IDX_W-1:0]       ownerId;
  logic [7:0]             holdCnt;

  logic [NUM_CLIENTS-1:0] ownerMask;
  logic [NUM_CLIENTS-1:0] elig;
  logic [NUM_CLIENTS-1:0] gnt;
  logic                   lockedNow;
  logic                   forcedRel;
  logic                   gntAny;
  logic [IDX_W-1:0]       gntIdx;
  logic                   gntWe;

  logic                   sramRead;
  logic                   sramWrite;
  logic [ADDR_W-1:0]      sramAddr;
  logic [DATA_W-1:0]      sramWdata;
  logic                   lockTimeout;
  logic [NUM_CLIENTS-1:0] cliRvalid;
  logic [DATA_W-1:0]      cliRdata;

  logic                   rdVld_p [0:RD_LAT];
  logic [IDX_W-1:0]       rdId_p  [0:RD_LAT];

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_CLIENTS - 1) ? '0 : idx + 1'b1;
  endfunction

  // First set bit of mask at or after ptr, wrapping; lower distance wins.
  function automatic logic [NUM_CLIENTS-1:0] pickRr(input logic [NUM_CLIENTS-1:0] mask,
                                                    input logic [IDX_W-1:0] ptr);
    logic [NUM_CLIENTS-1:0] oh;
    int                     idx;
    oh = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (mask[idx]) begin
        oh      = '0;
        oh[idx] = 1'b1;
      end
    end
    return oh;
  endfunction

  function automatic logic [IDX_W-1:0] idxOf(input logic [NUM_CLIENTS-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    ownerMask = NUM_CLIENTS'(1) << ownerId;
    elig      = bus.cli_req;
    lockedNow = 1'b0;
    forcedRel = 1'b0;
    // Dropping cli_lock releases voluntarily and leaves the owner eligible.
    if (ownerValid && bus.cli_lock[ownerId]) begin
      if (holdCnt == LOCK_LIM) begin
        forcedRel = 1'b1;
        elig      = bus.cli_req & ~ownerMask;
      end else begin
        lockedNow = 1'b1;
        elig      = bus.cli_req & ownerMask;
      end
    end
    gnt    = rst ? '0 : pickRr(elig, rrPtr);
    gntAny = |gnt;
    gntIdx = idxOf(gnt);
    gntWe  = bus.cli_we[gntIdx];
  end

  // Arbitration state: pointer, owner and hold counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr       <= '0;
      ownerValid  <= 1'b0;
      ownerId     <= '0;
      holdCnt     <= '0;
      lockTimeout <= 1'b0;
    end else begin
      lockTimeout <= forcedRel;
      if (gntAny)         rrPtr <= nextIdx(gntIdx);
      else if (forcedRel) rrPtr <= nextIdx(ownerId);
      if (lockedNow) begin
        holdCnt <= holdCnt + 8'd1;
      end else if (gntAny && bus.cli_lock[gntIdx]) begin
        ownerValid <= 1'b1;
        ownerId    <= gntIdx;
        holdCnt    <= 8'd1;
      end else begin
        ownerValid <= 1'b0;
        holdCnt    <= '0;
      end
    end
  end

  // Stage p0: SRAM command, zero when idle so the bus stays OR-compatible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sramRead  <= 1'b0;
      sramWrite <= 1'b0;
      sramAddr  <= '0;
      sramWdata <= '0;
    end else begin
      sramRead  <= gntAny & ~gntWe;
      sramWrite <= gntAny & gntWe;
      sramAddr  <= gntAny ? bus.cli_addr[int'(gntIdx)*ADDR_W +: ADDR_W] : '0;
      sramWdata <= gntAny ? bus.cli_wdata[int'(gntIdx)*DATA_W +: DATA_W] : '0;
    end
  end

  // Read tag pipeline p0..pRD_LAT, aligned with SRAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= RD_LAT; k++) rdVld_p[k] <= 1'b0;
    end else begin
      rdVld_p[0] <= gntAny & ~gntWe;
      for (int k = 1; k <= RD_LAT; k++) rdVld_p[k] <= rdVld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    rdId_p[0] <= gntIdx;
    for (int k = 1; k <= RD_LAT; k++) rdId_p[k] <= rdId_p[k-1];
  end

  // Return stage: capture SRAM data for the tagged client
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cliRvalid <= '0;
      cliRdata  <= '0;
    end else begin
      cliRvalid <= rdVld_p[RD_LAT] ? (NUM_CLIENTS'(1) << rdId_p[RD_LAT]) : '0;
      if (rdVld_p[RD_LAT]) cliRdata <= bus.sram_rdata;
    end
  end

  assign bus.cli_gnt      = gnt;
  assign bus.cli_rvalid   = cliRvalid;
  assign bus.cli_rdata    = cliRdata;
  assign bus.sram_read    = sramRead;
  assign bus.sram_write   = sramWrite;
  assign bus.sram_addr    = sramAddr;
  assign bus.sram_wdata   = sramWdata;
  assign bus.lock_timeout = lockTimeout;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: dutA (RD_LAT=0, LOCK_MAX=4) driven from a vector table,
// dutB (RD_LAT=2) for read latency and reset-during-read sequences.
module tb_sram_port_arbiter;
  localparam int N  = 6;
  localparam int AW = 16;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) busA ();
  sram_port_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) busB ();

  sram_port_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(0), .LOCK_MAX(4))
    dutA (.clk(clk), .rst(rstA), .bus(busA));
  sram_port_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .LOCK_MAX(4))
    dutB (.clk(clk), .rst(rstB), .bus(busB));

  // SRAM models: unwritten words read back as their address byte replicated
  bit [DW-1:0] memA [256];
  bit          memWrA [256];
  always @(posedge clk) begin
    if (busA.sram_write) begin
      memA[busA.sram_addr[7:0]]   <= busA.sram_wdata;
      memWrA[busA.sram_addr[7:0]] <= 1'b1;
    end
  end
  assign busA.sram_rdata = memWrA[busA.sram_addr[7:0]] ? memA[busA.sram_addr[7:0]]
                                                       : {16{busA.sram_addr[7:0]}};

  logic [DW-1:0] rdB1, rdB2;
  always @(posedge clk) begin
    rdB1 <= {16{busB.sram_addr[7:0]}};
    rdB2 <= rdB1;
  end
  assign busB.sram_rdata = rdB2;

  typedef struct {
    logic [5:0] req, lock, we, gnt, rv;
    logic       rd, wr, tmo;
    logic [7:0] rb;
  } vec_t;

  vec_t vecs [28];
  int   nVec = 0;
  int   nBad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [7:0] aByte [6];
    aByte = '{8'h20, 8'h21, 8'h10, 8'h23, 8'h10, 8'h25};

    //          req    lock   we     gnt    rv     rd    wr    tmo   rb
    vecs[0]  = '{6'h3F, 6'h00, 6'h00, 6'h01, 6'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{6'h3F, 6'h00, 6'h00, 6'h02, 6'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{6'h3F, 6'h00, 6'h00, 6'h04, 6'h01, 1'b1, 1'b0, 1'b0, 8'h20};
    vecs[3]  = '{6'h3F, 6'h00, 6'h00, 6'h08, 6'h02, 1'b1, 1'b0, 1'b0, 8'h21};
    vecs[4]  = '{6'h3F, 6'h00, 6'h00, 6'h10, 6'h04, 1'b1, 1'b0, 1'b0, 8'h10};
    vecs[5]  = '{6'h3F, 6'h00, 6'h00, 6'h20, 6'h08, 1'b1, 1'b0, 1'b0, 8'h23};
    vecs[6]  = '{6'h3F, 6'h00, 6'h00, 6'h01, 6'h10, 1'b1, 1'b0, 1'b0, 8'h10};
    vecs[7]  = '{6'h04, 6'h00, 6'h04, 6'h04, 6'h20, 1'b1, 1'b0, 1'b0, 8'h25};
    vecs[8]  = '{6'h10, 6'h00, 6'h00, 6'h10, 6'h01, 1'b0, 1'b1, 1'b0, 8'h20};
    vecs[9]  = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h10, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[11] = '{6'h02, 6'h02, 6'h00, 6'h02, 6'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{6'h0B, 6'h02, 6'h00, 6'h02, 6'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[13] = '{6'h0B, 6'h02, 6'h00, 6'h02, 6'h02, 1'b1, 1'b0, 1'b0, 8'h21};
    vecs[14] = '{6'h09, 6'h00, 6'h00, 6'h08, 6'h02, 1'b1, 1'b0, 1'b0, 8'h21};
    vecs[15] = '{6'h09, 6'h00, 6'h00, 6'h01, 6'h02, 1'b1, 1'b0, 1'b0, 8'h21};
    vecs[16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 1'b1, 1'b0, 1'b0, 8'h23};
    vecs[17] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 1'b0, 1'b0, 1'b0, 8'h20};
    vecs[18] = '{6'h21, 6'h20, 6'h00, 6'h20, 6'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[19] = '{6'h21, 6'h20, 6'h00, 6'h20, 6'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[20] = '{6'h21, 6'h20, 6'h00, 6'h20, 6'h20, 1'b1, 1'b0, 1'b0, 8'h25};
    vecs[21] = '{6'h21, 6'h20, 6'h00, 6'h20, 6'h20, 1'b1, 1'b0, 1'b0, 8'h25};
    vecs[22] = '{6'h21, 6'h20, 6'h00, 6'h01, 6'h20, 1'b1, 1'b0, 1'b0, 8'h25};
    vecs[23] = '{6'h21, 6'h20, 6'h00, 6'h20, 6'h20, 1'b1, 1'b0, 1'b1, 8'h25};
    vecs[24] = '{6'h01, 6'h20, 6'h00, 6'h00, 6'h01, 1'b1, 1'b0, 1'b0, 8'h20};
    vecs[25] = '{6'h01, 6'h00, 6'h00, 6'h01, 6'h20, 1'b0, 1'b0, 1'b0, 8'h25};
    vecs[26] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[27] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 1'b0, 1'b0, 1'b0, 8'h20};

    busA.cli_req = '0; busA.cli_lock = '0; busA.cli_we = '0;
    busB.cli_req = '0; busB.cli_lock = '0; busB.cli_we = '0;
    for (int i = 0; i < N; i++) begin
      busA.cli_addr[i*AW +: AW]  = {8'h00, aByte[i]};
      busA.cli_wdata[i*DW +: DW] = (i == 2) ? {16{8'hA5}} : {16{8'h50 + 8'(i)}};
      busB.cli_addr[i*AW +: AW]  = 16'h0030 + 16'(i);
      busB.cli_wdata[i*DW +: DW] = '0;
    end

    // Reset holds grants off even with requests present
    rstA = 1'b1; rstB = 1'b1;
    @(negedge clk);
    busA.cli_req = 6'h3F;
    #1;
    chk("reset gnt", busA.cli_gnt, 0);
    chk("reset rd", busA.sram_read, 0);
    chk("reset rvalid", busA.cli_rvalid, 0);
    @(negedge clk);
    busA.cli_req = '0;
    rstA = 1'b0; rstB = 1'b0;

    for (int v = 0; v < 28; v++) begin
      @(negedge clk);
      busA.cli_req  = vecs[v].req;
      busA.cli_lock = vecs[v].lock;
      busA.cli_we   = vecs[v].we;
      #1;
      chk($sformatf("v%0d gnt", v), busA.cli_gnt, vecs[v].gnt);
      chk($sformatf("v%0d rvalid", v), busA.cli_rvalid, vecs[v].rv);
      chk($sformatf("v%0d sram_read", v), busA.sram_read, vecs[v].rd);
      chk($sformatf("v%0d sram_write", v), busA.sram_write, vecs[v].wr);
      chk($sformatf("v%0d lock_timeout", v), busA.lock_timeout, vecs[v].tmo);
      if (vecs[v].rv != 6'h00)
        chk($sformatf("v%0d rdata", v), busA.cli_rdata, {16{vecs[v].rb}});
      if (!vecs[v].rd && !vecs[v].wr) begin
        chk($sformatf("v%0d idle addr", v), busA.sram_addr, 0);
        chk($sformatf("v%0d idle wdata", v), busA.sram_wdata, 0);
      end
    end

    // Reset mid-traffic: pointer at 2 before reset, back to 0 after
    @(negedge clk);
    busA.cli_req = 6'h3F; busA.cli_lock = '0; busA.cli_we = '0;
    #1;
    chk("pre-reset gnt", busA.cli_gnt, 6'h02);
    @(negedge clk);
    busA.cli_req = 6'h0A;
    rstA = 1'b1;
    #1;
    chk("async rst gnt", busA.cli_gnt, 0);
    chk("async rst sram_read", busA.sram_read, 0);
    chk("async rst sram_addr", busA.sram_addr, 0);
    chk("async rst rvalid", busA.cli_rvalid, 0);
    chk("async rst rdata", busA.cli_rdata, 0);
    chk("async rst timeout", busA.lock_timeout, 0);
    @(negedge clk);
    rstA = 1'b0;
    #1;
    chk("post-reset gnt", busA.cli_gnt, 6'h02);
    @(negedge clk);
    busA.cli_req = '0;

    // dutB: read latency 2 puts rvalid four cycles after the grant
    @(negedge clk);
    busB.cli_req = 6'h08;
    #1;
    chk("B gnt", busB.cli_gnt, 6'h08);
    @(negedge clk);
    busB.cli_req = '0;
    #1;
    chk("B sram_read", busB.sram_read, 1);
    chk("B sram_addr", busB.sram_addr, 16'h0033);
    for (int c = 2; c < 4; c++) begin
      @(negedge clk); #1;
      chk($sformatf("B early rvalid t+%0d", c), busB.cli_rvalid, 0);
    end
    @(negedge clk); #1;
    chk("B rvalid t+4", busB.cli_rvalid, 6'h08);
    chk("B rdata t+4", busB.cli_rdata, {16{8'h33}});

    // dutB: reset pulse two cycles after a read grant discards the read
    @(negedge clk);
    busB.cli_req = 6'h01;
    #1;
    chk("B2 gnt", busB.cli_gnt, 6'h01);
    @(negedge clk);
    busB.cli_req = '0;
    @(negedge clk);
    rstB = 1'b1;
    #2;
    rstB = 1'b0;
    chk("B2 rdata cleared", busB.cli_rdata, 0);
    for (int c = 2; c < 7; c++) begin
      if (c > 2) begin
        @(negedge clk); #1;
      end
      chk($sformatf("B2 rvalid t+%0d", c), busB.cli_rvalid, 0);
      chk($sformatf("B2 sram_read t+%0d", c), busB.sram_read, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
